// File: rtl/prefetch_pkg.sv
// Shared types and default sizing for the instruction prefetch unit.
package prefetch_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 4;
    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_PC_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} entries; head is read combinationally.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_DATA_W + DEFAULT_PC_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: streams sequential words from instruction RAM into a PC-tagged FIFO.
module instr_prefetch
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned PC_W   = DEFAULT_PC_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [PC_W-1:0]   instr_pc,
    output logic [CNT_W-1:0]  occupancy
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic              pending_q, pending_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;

    logic [CNT_W:0]           in_flight;
    logic                     credit_ok;
    logic                     push;
    logic                     pop;
    logic [DATA_W+PC_W-1:0]   head;

    // A request occupies a slot from issue (mem_en cycle) through its data cycle (pending).
    assign in_flight = {1'b0, occupancy} + {{CNT_W{1'b0}}, mem_en_q}
                     + {{CNT_W{1'b0}}, pending_q};
    assign credit_ok = in_flight < (CNT_W + 1)'(DEPTH);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        req_pc_d   = req_pc_q;
        pending_d  = mem_en_q;
        rsp_pc_d   = req_pc_q;

        if (flush) begin
            // Kills the request currently on the memory port as well as the data arriving now.
            state_d    = S_FLUSH;
            fetch_pc_d = flush_pc;
            pending_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (credit_ok) begin
                        mem_en_d   = 1'b1;
                        mem_addr_d = fetch_pc_q[ADDR_W-1:0];
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                    end
                end
                S_FLUSH: begin
                    state_d = S_STREAM;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            req_pc_q   <= '0;
            pending_q  <= 1'b0;
            rsp_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            req_pc_q   <= req_pc_d;
            pending_q  <= pending_d;
            rsp_pc_q   <= rsp_pc_d;
        end
    end

    assign push = pending_q && !flush;
    assign pop  = instr_valid && instr_ready && !flush;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + PC_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({mem_rdata, rsp_pc_q}),
        .head  (head),
        .count (occupancy)
    );

    assign instr_valid = (occupancy != '0);
    assign instr_data  = head[PC_W +: DATA_W];
    assign instr_pc    = head[PC_W-1:0];

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch against an in-order stream model and a fetch-address model.
module tb_instr_prefetch;
    import prefetch_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              flush = 1'b0;
    logic [PC_W-1:0]   flush_pc = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b1;
    logic [DATA_W-1:0] instr_data;
    logic [PC_W-1:0]   instr_pc;
    logic [CNT_W-1:0]  occupancy;

    instr_prefetch #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .occupancy   (occupancy)
    );

    always #5 clock = ~clock;

    // Single-port RAM with one cycle of read latency.
    logic [DATA_W-1:0] ram [256];
    always @(posedge clock) begin
        if (mem_en) mem_rdata <= ram[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the accepted stream is the sequence of PCs from the last restart point,
    // each carrying ram[pc mod 256]; memory requests walk the same sequence.
    logic [PC_W-1:0] exp_pc    = '0;
    logic [PC_W-1:0] exp_fetch = '0;
    bit              prev_flush = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            exp_pc     = '0;
            exp_fetch  = '0;
            prev_flush = 1'b0;
        end else begin
            check("valid_vs_occ", 64'(instr_valid), 64'(occupancy != '0));
            check("occ_bound", 64'(occupancy <= CNT_W'(DEPTH)), 64'd1);
            check("mem_write_tied", 64'({mem_we, mem_wdata}), 64'd0);
            if (prev_flush) begin
                check("valid_after_flush", 64'(instr_valid), 64'd0);
                check("mem_en_after_flush", 64'(mem_en), 64'd0);
            end
            if (mem_en) begin
                check("mem_addr", 64'(mem_addr), 64'(exp_fetch[ADDR_W-1:0]));
                exp_fetch++;
            end
            if (flush) begin
                exp_pc    = flush_pc;
                exp_fetch = flush_pc;
            end else if (instr_valid && instr_ready) begin
                check("instr_pc", 64'(instr_pc), 64'(exp_pc));
                check("instr_data", 64'(instr_data), 64'(ram[exp_pc[ADDR_W-1:0]]));
                exp_pc++;
                n_accept++;
            end
            prev_flush = flush;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_valid"}, 64'(instr_valid), 64'd0);
        check({tag, "_data"}, 64'(instr_data), 64'd0);
        check({tag, "_pc"}, 64'(instr_pc), 64'd0);
        check({tag, "_occ"}, 64'(occupancy), 64'd0);
    endtask

    // Called just after a clock edge: release reset and check the first-word latency.
    task automatic release_and_check_latency(input string tag);
        int waited;
        reset = 1'b0;
        tick();
        check({tag, "_early1"}, 64'(instr_valid), 64'd0);
        tick();
        check({tag, "_early2"}, 64'(instr_valid), 64'd0);
        waited = 0;
        while (!instr_valid && waited < 8) begin
            tick();
            waited++;
        end
        check({tag, "_first_valid"}, 64'(instr_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int waited;
        for (int i = 0; i < 256; i++) begin
            if (i < 8) ram[i] = 32'hA000_0000 + i;
            else       ram[i] = $urandom;
        end

        // Reset state and first stream.
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        release_and_check_latency("boot");
        hi = 0;
        repeat (8) begin
            tick();
            if (instr_valid) hi++;
        end
        check("steady_rate", 64'(hi), 64'd8);

        // Back-pressure saturates the FIFO and stops requests.
        instr_ready = 1'b0;
        repeat (10) tick();
        check("sat_occ", 64'(occupancy), 64'd4);
        check("sat_mem_en", 64'(mem_en), 64'd0);
        instr_ready = 1'b1;
        repeat (8) tick();

        // Flush with three words buffered and a request in flight.
        instr_ready = 1'b0;
        waited = 0;
        while (occupancy != CNT_W'(3) && waited < 20) begin
            tick();
            waited++;
        end
        check("occ_reach3", 64'(occupancy), 64'd3);
        flush    = 1'b1;
        flush_pc = 16'h0010;
        tick();
        flush       = 1'b0;
        instr_ready = 1'b1;
        repeat (12) tick();

        // Flush coinciding with a pop, then two consecutive flushes.
        check("pre_flush_valid", 64'(instr_valid), 64'd1);
        flush    = 1'b1;
        flush_pc = 16'h0020;
        tick();
        flush_pc = 16'h0030;
        tick();
        flush = 1'b0;
        repeat (12) tick();

        // Address and PC wrap.
        flush    = 1'b1;
        flush_pc = 16'h00FE;
        tick();
        flush = 1'b0;
        repeat (12) tick();
        flush    = 1'b1;
        flush_pc = 16'hFFFF;
        tick();
        flush = 1'b0;
        repeat (10) tick();

        // Random ready and flush traffic.
        repeat (400) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 31) == 0);
            flush_pc    = PC_W'($urandom);
            tick();
        end
        flush       = 1'b0;
        instr_ready = 1'b1;
        repeat (10) tick();

        // Asynchronous reset mid-stream with a read outstanding.
        waited = 0;
        while (!mem_en && waited < 10) begin
            tick();
            waited++;
        end
        check("mem_en_before_reset", 64'(mem_en), 64'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        release_and_check_latency("rerun");
        repeat (10) tick();

        check("accepted_words", 64'(n_accept > 100), 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
